horizontal_fold_ctrl: RTL and testbench

// Sequencer for horizontal_fold, the vec4 -> scalar sum unit built on one pipelined fp_add.

---
 rtl/horizontal_fold_ctrl.sv | 129 ++++++++++++
 tb/tb_horizontal_fold_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/horizontal_fold_ctrl.sv
// horizontal_fold_ctrl: sequencer for the vec4 -> scalar horizontal_fold unit.
// Each vec4 makes three passes through one pipelined fp_add. Up to STAGES
// vectors are interleaved through a ring of slots.
// The optional perf counters are enabled by defining HFOLD_CTRL_PERF_EN.

module horizontal_fold_ctrl #(
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    output logic             fold_stall,
    output logic             fold_fb,
    output logic             fold_fb_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag
`ifdef HFOLD_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_folds,
    output logic [31:0]      perf_stalls
`endif
);

    localparam int PTR_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    // FREE: empty. P1: waiting for the +v2 pass. P2: waiting for +v3.
    // P3: final sum is on the adder output this cycle.
    typedef enum logic [1:0] {FREE, P1, P2, P3} phase_e;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    phase_e           phase_q [STAGES];
    phase_e           phase_d [STAGES];
    logic [TAG_W-1:0] tag_q   [STAGES];
    logic [TAG_W-1:0] tag_d   [STAGES];
    logic             out_valid_q, out_valid_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    phase_e           head_phase;
    logic             head_free;

    assign head_phase = phase_q[ptr_q];
    // A P3 head retires this cycle, so it can take a new vector immediately.
    assign head_free  = (head_phase == FREE) || (head_phase == P3);

    // Handshake and fold control decode for the head slot, plus next state.
    always_comb begin
        ptr_d       = ptr_q;
        phase_d     = phase_q;
        tag_d       = tag_q;
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;

        // Downstream back-pressure freezes the ring and the adder together.
        fold_stall   = ~rst & out_valid_q & ~out_ready;
        in_ready     = ~rst & ~fold_stall & head_free;
        fold_fb      = ~rst & ((head_phase == P1) || (head_phase == P2));
        fold_fb_last = ~rst & (head_phase == P2);

        if (!fold_stall) begin
            ptr_d = (ptr_q == PTR_W'(STAGES - 1)) ? '0 : ptr_q + PTR_W'(1);
            // Output register lines up with the fold's skid-registered q.
            out_valid_d = (head_phase == P3);
            out_tag_d   = tag_q[ptr_q];
            unique case (head_phase)
                P1:      phase_d[ptr_q] = P2;
                P2:      phase_d[ptr_q] = P3;
                default: begin
                    if (in_valid) begin
                        phase_d[ptr_q] = P1;
                        tag_d[ptr_q]   = in_tag;
                    end else begin
                        phase_d[ptr_q] = FREE;
                    end
                end
            endcase
        end
    end

    // Slot ring and output register; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                phase_q[i] <= FREE;
                tag_q[i]   <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            phase_q     <= phase_d;
            tag_q       <= tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;

`ifdef HFOLD_CTRL_PERF_EN
    logic [31:0] perf_folds_q, perf_folds_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    // Event counters; wrap naturally at 2^32.
    always_comb begin
        perf_folds_d  = perf_folds_q + {31'd0, out_valid_q & out_ready};
        perf_stalls_d = perf_stalls_q + {31'd0, fold_stall};
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_folds_q  <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_folds_q  <= perf_folds_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_folds  = perf_folds_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_horizontal_fold_ctrl.sv
// Scoreboard bench for horizontal_fold_ctrl. The reference model tracks time in
// "active cycles" (cycles without stall): a vector accepted at active cycle a
// occupies slot a%S until a+3S and its result is presented at a+3S+1.
module tb_horizontal_fold_ctrl;
    localparam int S     = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag;
    logic             fold_stall;
    logic             fold_fb;
    logic             fold_fb_last;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
`ifdef HFOLD_CTRL_PERF_EN
    logic [31:0]      perf_folds;
    logic [31:0]      perf_stalls;
`endif

    horizontal_fold_ctrl #(.STAGES(S), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_tag      (in_tag),
        .fold_stall  (fold_stall),
        .fold_fb     (fold_fb),
        .fold_fb_last(fold_fb_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_tag     (out_tag)
`ifdef HFOLD_CTRL_PERF_EN
        ,
        .perf_folds  (perf_folds),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        int               due;
    } exp_t;

    exp_t        sb_q[$];
    int          ac;
    int          last_acc [S];
    int          errors = 0;
    int          checks = 0;
    logic        rst_prev = 1'b0;
    int unsigned exp_folds, exp_stalls;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model and monitor: sampled on the falling edge.
    always @(negedge clk) begin
        int   slot, d;
        logic present, exp_stall, exp_rdy;
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_stall", fold_stall, 0);
            chk("rst_fb", {fold_fb, fold_fb_last}, 0);
            if (rst_prev) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_tag", out_tag, 0);
            end
            sb_q.delete();
            ac = 0;
            exp_folds = 0;
            exp_stalls = 0;
            for (int i = 0; i < S; i++) last_acc[i] = -1000;
        end else begin
            slot      = ac % S;
            d         = ac - last_acc[slot];
            present   = (sb_q.size() > 0) && (sb_q[0].due == ac);
            exp_stall = present & ~out_ready;
            exp_rdy   = ~exp_stall & (d >= 3 * S);
            chk("out_valid", out_valid, present);
            if (present) chk("out_tag", out_tag, sb_q[0].tag);
            chk("fold_stall", fold_stall, exp_stall);
            chk("in_ready", in_ready, exp_rdy);
            chk("fold_fb", fold_fb, (d == S) || (d == 2 * S));
            chk("fold_fb_last", fold_fb_last, d == 2 * S);
`ifdef HFOLD_CTRL_PERF_EN
            chk("perf_folds", perf_folds, exp_folds);
            chk("perf_stalls", perf_stalls, exp_stalls);
`endif
            if (present && out_ready) begin
                void'(sb_q.pop_front());
                exp_folds++;
            end
            if (exp_stall) exp_stalls++;
            if (exp_rdy && in_valid) begin
                sb_q.push_back('{tag: in_tag, due: ac + 3 * S + 1});
                last_acc[slot] = ac;
            end
            if (!exp_stall) ac++;
        end
        rst_prev = rst;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [TAG_W-1:0] t;
        logic             acc;
        rst = 1'b1; in_valid = 1'b0; in_tag = '0; out_ready = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;

        // Single vector, tag 5.
        in_valid = 1'b1; in_tag = 4'd5;
        cyc();
        in_valid = 1'b0;
        repeat (20) cyc();

        // Back-to-back tags 0..4 with in_valid held, output blocked 13..17.
        t = 0;
        for (int k = 0; k < 40; k++) begin
            in_valid  = (t < 5);
            in_tag    = t;
            out_ready = !(k >= 13 && k <= 17);
            #1;
            acc = in_valid & in_ready;
            @(posedge clk); #1;
            if (acc) t++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) cyc();

        // Reset at cycle 6 with three vectors in flight.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_tag = 4'(k + 8);
            cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (20) cyc();
        in_valid = 1'b1; in_tag = 4'hA;
        cyc();
        in_valid = 1'b0;
        repeat (16) cyc();

        // Sparse input, one offer every 5th cycle.
        for (int k = 0; k < 50; k++) begin
            in_valid = (k % 5 == 0);
            in_tag   = 4'(k / 5);
            cyc();
        end
        in_valid = 1'b0;

        // Randomized traffic with back-pressure and occasional reset.
        for (int k = 0; k < 1500; k++) begin
            in_valid  = ($urandom % 3) != 0;
            in_tag    = 4'($urandom);
            out_ready = ($urandom % 4) != 0;
            rst       = ($urandom % 300) == 0;
            cyc();
        end
        rst = 1'b0;

        // Drain.
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4 * S + 10) cyc();
        @(negedge clk); #1;
        chk("drain_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
